// File: rtl/debug_trace_buffer_if.sv
// Probe/control/display bundle for the debug trace buffer.
// The master side drives probes, switches and strobes; the slave side is the buffer.
interface debug_trace_buffer_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic                     step_pulse;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]         ch_sel;
  logic [1:0]               mode;
  logic                     trig_en;
  logic [DATA_W-1:0]        trig_value;
  logic                     rd_next;
  logic                     rd_prev;
  logic [DATA_W-1:0]        disp_data;
  logic [IDX_W-1:0]         rd_idx;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     triggered;
  logic [1:0]               state_o;

  modport master (
    output step_pulse, ch_data, ch_sel, mode, trig_en, trig_value, rd_next, rd_prev,
    input  disp_data, rd_idx, count, full, triggered, state_o
  );

  modport slave (
    input  step_pulse, ch_data, ch_sel, mode, trig_en, trig_value, rd_next, rd_prev,
    output disp_data, rd_idx, count, full, triggered, state_o
  );
endinterface

// File: rtl/debug_trace_buffer.sv
// Channel-selectable probe capture into a ring buffer with optional trigger arming,
// plus entry-by-entry replay onto the display outputs.
module debug_trace_buffer #(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  debug_trace_buffer_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_LIVE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_CAPT   = 2'b10,
    ST_REPLAY = 2'b11
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              triggered_q, triggered_d;
  logic [DATA_W-1:0] disp_q, disp_d;

  logic [DATA_W-1:0] sel_val_s;
  logic [IDX_W-1:0]  oldest_s;
  logic [IDX_W-1:0]  rd_addr_s;
  logic              can_inc_s;
  logic              block_s;
  logic              we_s;

  // Channel mux; an out-of-range select reads as zero rather than X.
  always_comb begin
    sel_val_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_val_s = (bus.ch_sel == SEL_W'(k)) ? bus.ch_data[k*DATA_W +: DATA_W] : sel_val_s;
    end
  end

  assign oldest_s  = full_q ? wr_ptr_q : '0;
  assign rd_addr_s = oldest_s + rd_idx_q;
  assign can_inc_s = ({1'b0, rd_idx_q} + CNT_W'(1)) < count_q;
  assign block_s   = full_q & STOP_ON_FULL;

  // Next-state and output decode; the mode switches take priority over strobes.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_idx_d    = rd_idx_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    disp_d      = sel_val_s;
    we_s        = 1'b0;

    case (bus.mode)
      2'b01: begin
        if ((state_q == ST_LIVE) || (state_q == ST_REPLAY)) begin
          wr_ptr_d    = '0;
          count_d     = '0;
          triggered_d = 1'b0;
          state_d     = bus.trig_en ? ST_ARMED : ST_CAPT;
        end else if (state_q == ST_ARMED) begin
          if (bus.step_pulse && (sel_val_s == bus.trig_value)) begin
            we_s        = 1'b1;
            wr_ptr_d    = wr_ptr_q + IDX_W'(1);
            count_d     = count_q + CNT_W'(1);
            triggered_d = 1'b1;
            state_d     = ST_CAPT;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          if (bus.step_pulse && !block_s) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            count_d  = full_q ? count_q : (count_q + CNT_W'(1));
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
        end
      end
      2'b10: begin
        if (state_q != ST_REPLAY) begin
          state_d  = ST_REPLAY;
          rd_idx_d = '0;
          disp_d   = (count_q == '0) ? '0 : mem_q[oldest_s];
        end else begin
          disp_d = (count_q == '0) ? '0 : mem_q[rd_addr_s];
          case ({bus.rd_next, bus.rd_prev})
            2'b10:   rd_idx_d = can_inc_s ? (rd_idx_q + IDX_W'(1)) : rd_idx_q;
            2'b01:   rd_idx_d = (rd_idx_q != '0) ? (rd_idx_q - IDX_W'(1)) : rd_idx_q;
            default: rd_idx_d = rd_idx_q;
          endcase
        end
      end
      default: begin
        state_d = ST_LIVE;
      end
    endcase

    full_d = (count_d == CNT_FULL);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LIVE;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      triggered_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      count_q     <= count_d;
      full_q      <= full_d;
      triggered_q <= triggered_d;
      disp_q      <= disp_d;
    end
  end

  // Sample storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_q[wr_ptr_q] <= sel_val_s;
    end
  end

  assign bus.disp_data = disp_q;
  assign bus.rd_idx    = rd_idx_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.triggered = triggered_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench: two instances (overwrite and stop-on-full) share one stimulus stream.
module tb_debug_trace_buffer;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     step;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [2:0]               ch_sel;
  logic [1:0]               mode;
  logic                     trig_en;
  logic [31:0]              trig_value;
  logic                     rd_next;
  logic                     rd_prev;

  int total = 0;
  int bad   = 0;

  debug_trace_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) if0 ();
  debug_trace_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) if1 ();

  assign if0.step_pulse = step;
  assign if0.ch_data    = ch_data;
  assign if0.ch_sel     = ch_sel;
  assign if0.mode       = mode;
  assign if0.trig_en    = trig_en;
  assign if0.trig_value = trig_value;
  assign if0.rd_next    = rd_next;
  assign if0.rd_prev    = rd_prev;
  assign if1.step_pulse = step;
  assign if1.ch_data    = ch_data;
  assign if1.ch_sel     = ch_sel;
  assign if1.mode       = mode;
  assign if1.trig_en    = trig_en;
  assign if1.trig_value = trig_value;
  assign if1.rd_next    = rd_next;
  assign if1.rd_prev    = rd_prev;

  debug_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .STOP_ON_FULL(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  debug_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .STOP_ON_FULL(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [1:0]  mode;
    logic        step;
    logic [31:0] v;
    logic        nx;
    logic        pv;
    logic [1:0]  e_state;
    logic [4:0]  e_count;
    logic [3:0]  e_idx;
    logic [31:0] e_disp;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    ch_data[k*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; ch_data = '0; ch_sel = 3'd2; mode = 2'b00;
    trig_en = 1'b0; trig_value = 32'h0; rd_next = 1'b0; rd_prev = 1'b0;
    set_ch(2, 32'h0000_ABCD);

    // Test 1: reset values, then live view
    @(negedge clk);
    cyc(); cyc();
    check("rst state", 32'(if0.state_o), 32'd0);
    check("rst count", 32'(if0.count), 32'd0);
    check("rst disp", if0.disp_data, 32'd0);
    check("rst idx", 32'(if0.rd_idx), 32'd0);
    check("rst full", 32'(if0.full), 32'd0);
    check("rst trig", 32'(if0.triggered), 32'd0);
    rst = 1'b0;
    cyc();
    check("live disp", if0.disp_data, 32'h0000_ABCD);
    check("live disp1", if1.disp_data, 32'h0000_ABCD);

    // Test 2: five samples, replay, navigation
    ch_sel = 3'd1;
    tbl[0]  = '{2'b01, 1'b0, 32'h10, 1'b0, 1'b0, 2'b10, 5'd0, 4'd0, 32'h10};
    tbl[1]  = '{2'b01, 1'b1, 32'h10, 1'b0, 1'b0, 2'b10, 5'd1, 4'd0, 32'h10};
    tbl[2]  = '{2'b01, 1'b1, 32'h11, 1'b0, 1'b0, 2'b10, 5'd2, 4'd0, 32'h11};
    tbl[3]  = '{2'b01, 1'b1, 32'h12, 1'b0, 1'b0, 2'b10, 5'd3, 4'd0, 32'h12};
    tbl[4]  = '{2'b01, 1'b1, 32'h13, 1'b0, 1'b0, 2'b10, 5'd4, 4'd0, 32'h13};
    tbl[5]  = '{2'b01, 1'b1, 32'h14, 1'b0, 1'b0, 2'b10, 5'd5, 4'd0, 32'h14};
    tbl[6]  = '{2'b10, 1'b0, 32'h99, 1'b0, 1'b0, 2'b11, 5'd5, 4'd0, 32'h10};
    tbl[7]  = '{2'b10, 1'b0, 32'h99, 1'b1, 1'b0, 2'b11, 5'd5, 4'd1, 32'h10};
    tbl[8]  = '{2'b10, 1'b0, 32'h99, 1'b1, 1'b0, 2'b11, 5'd5, 4'd2, 32'h11};
    tbl[9]  = '{2'b10, 1'b0, 32'h99, 1'b0, 1'b0, 2'b11, 5'd5, 4'd2, 32'h12};
    tbl[10] = '{2'b10, 1'b0, 32'h99, 1'b1, 1'b1, 2'b11, 5'd5, 4'd2, 32'h12};
    tbl[11] = '{2'b10, 1'b1, 32'h77, 1'b0, 1'b0, 2'b11, 5'd5, 4'd2, 32'h12};
    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode; step = tbl[i].step; set_ch(1, tbl[i].v);
      rd_next = tbl[i].nx; rd_prev = tbl[i].pv;
      cyc();
      check($sformatf("t2[%0d] state", i), 32'(if0.state_o), 32'(tbl[i].e_state));
      check($sformatf("t2[%0d] count", i), 32'(if0.count), 32'(tbl[i].e_count));
      check($sformatf("t2[%0d] idx", i), 32'(if0.rd_idx), 32'(tbl[i].e_idx));
      check($sformatf("t2[%0d] disp", i), if0.disp_data, tbl[i].e_disp);
    end
    step = 1'b0; rd_next = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    rd_next = 1'b0;
    cyc();
    check("t2 sat idx", 32'(if0.rd_idx), 32'd4);
    check("t2 sat disp", if0.disp_data, 32'h14);
    rd_prev = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    rd_prev = 1'b0;
    cyc();
    check("t2 prev idx", 32'(if0.rd_idx), 32'd0);
    check("t2 prev disp", if0.disp_data, 32'h10);
    check("t2 trig", 32'(if0.triggered), 32'd0);
    mode = 2'b00;
    cyc();
    check("t2 live state", 32'(if0.state_o), 32'd0);
    check("t2 live count", 32'(if0.count), 32'd5);
    check("t2 live disp", if0.disp_data, 32'h77);
    mode = 2'b10;
    cyc();
    check("t2 rereplay disp", if0.disp_data, 32'h10);
    check("t2 rereplay count", 32'(if0.count), 32'd5);

    // Tests 3/4: 20 samples, overwrite (dut0) vs stop-on-full (dut1)
    mode = 2'b00; cyc();
    mode = 2'b01; trig_en = 1'b0; cyc();
    for (int i = 0; i < 20; i++) begin
      step = 1'b1; set_ch(1, 32'(i));
      cyc();
    end
    step = 1'b0;
    cyc();
    check("t3 count", 32'(if0.count), 32'd16);
    check("t3 full", 32'(if0.full), 32'd1);
    check("t4 count", 32'(if1.count), 32'd16);
    check("t4 full", 32'(if1.full), 32'd1);
    check("t4 state", 32'(if1.state_o), 32'd2);
    mode = 2'b10;
    cyc();
    check("t3 r0", if0.disp_data, 32'd4);
    check("t4 r0", if1.disp_data, 32'd0);
    for (int i = 1; i < 16; i++) begin
      rd_next = 1'b1; cyc();
      rd_next = 1'b0; cyc();
      check($sformatf("t3 idx%0d", i), 32'(if0.rd_idx), 32'(i));
      check($sformatf("t3 r%0d", i), if0.disp_data, 32'(i + 4));
      check($sformatf("t4 r%0d", i), if1.disp_data, 32'(i));
    end
    rd_next = 1'b1; cyc();
    rd_next = 1'b0; cyc();
    check("t3 idx sat", 32'(if0.rd_idx), 32'd15);
    check("t3 r sat", if0.disp_data, 32'd19);

    // Test 5: trigger arming
    mode = 2'b00; cyc();
    mode = 2'b01; trig_en = 1'b1; trig_value = 32'h33;
    cyc();
    check("t5 armed", 32'(if0.state_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1; set_ch(1, 32'h31 + 32'(i));
      cyc();
      check($sformatf("t5 state%0d", i), 32'(if0.state_o), (i < 2) ? 32'd1 : 32'd2);
      check($sformatf("t5 count%0d", i), 32'(if0.count), (i < 2) ? 32'd0 : 32'(i - 1));
      check($sformatf("t5 trig%0d", i), 32'(if0.triggered), (i < 2) ? 32'd0 : 32'd1);
    end
    step = 1'b0; mode = 2'b10;
    cyc();
    check("t5 r0", if0.disp_data, 32'h33);
    rd_next = 1'b1; cyc();
    rd_next = 1'b0; cyc();
    check("t5 r1", if0.disp_data, 32'h34);
    check("t5 idx1", 32'(if0.rd_idx), 32'd1);

    // Test 6: reset wins over a concurrent step_pulse mid-capture
    mode = 2'b00; trig_en = 1'b0; cyc();
    mode = 2'b01; cyc();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; set_ch(1, 32'h50 + 32'(i));
      cyc();
    end
    check("t6 count3", 32'(if0.count), 32'd3);
    rst = 1'b1; step = 1'b1;
    cyc();
    check("t6 rst state", 32'(if0.state_o), 32'd0);
    check("t6 rst count", 32'(if0.count), 32'd0);
    check("t6 rst disp", if0.disp_data, 32'd0);
    rst = 1'b0; step = 1'b0; mode = 2'b10;
    cyc();
    check("t6 replay state", 32'(if0.state_o), 32'd3);
    check("t6 replay disp", if0.disp_data, 32'd0);
    rd_next = 1'b1; cyc();
    rd_next = 1'b0;
    check("t6 empty idx", 32'(if0.rd_idx), 32'd0);
    check("t6 empty disp", if0.disp_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
